tach_sample_scheduler: RTL and testbench
========================================

# tach_sample_scheduler

Periodic RPM sampling controller for the two drive motors of the wall follower. It counts tachometer rising edges on both channels over a fixed window and shares one serial divide-by-3 unit between the channels to convert counts to RPM. It then publishes the pair to the PID stage with a valid/ready handshake. The block replaces per-motor free-running samplers and defines the PID update tick.

## Interface
- SAMPLE_TICKS, 1_250_000: window length in clk_in cycles (10 ms at 125 MHz); must be ≥ 64.
- DEBOUNCE_CYCLES, 8: stable-level cycles required per edge (only with macro enabled).
- clk_in  input  1  system clock, 125 MHz.
- reset_n_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  sampling run/stop.
- tach_a_in  input  1  raw tachometer pulse, motor A (asynchronous).
- tach_b_in  input  1  raw tachometer pulse, motor B (asynchronous).
- rpm_ready_in  input  1  PID has consumed current sample.
- rpm_a_out  output  10  motor A RPM.
- rpm_b_out  output  10  motor B RPM.
- rpm_valid_out  output  1  sample pair available.
- sat_a_out, sat_b_out  output  1 each  RPM of latest sample was clamped.
- overrun_out  output  1  sticky: a sample was overwritten before it was accepted.

## Operation
- Each tach input passes through a 2-flop synchronizer. A rising edge is a synchronized 0→1 transition.
- Edge counters are 16 bits and saturate at 0xFFFF. The window counter runs 0..SAMPLE_TICKS-1 while enabled.
- Boundary cycle (window counter = SAMPLE_TICKS-1):
  - snapshot_x ← count_x + edge_x (saturating);
  - count_x ← 0;
  - an edge in this cycle belongs to the old window.
- Counting of the next window continues during conversion.
- RPM = floor(snapshot × 50 / 3), for 360 pulses/rev and a 10 ms window.
  - Numerator is 22 bits. It is computed with a restoring divider, 1 quotient bit per cycle, 22 cycles, shared by A then B.
  - A quotient > 1023 yields 1023 and sets sat_x_out for that sample.
- FSM states and transitions:
  - IDLE → COUNT when enable_in = 1.
  - COUNT → DIV_A on the boundary cycle.
  - DIV_A (22 cycles) → DIV_B (22 cycles) → PUBLISH (1 cycle) → COUNT.
- PUBLISH loads rpm_a_out, rpm_b_out and sat flags, and sets rpm_valid_out.
  - If rpm_valid_out is already 1 (not yet accepted), overrun_out is set and the new values overwrite the old.
- Handshake: the transfer occurs on a cycle with rpm_valid_out & rpm_ready_in; rpm_valid_out clears on the next edge.
  - If PUBLISH coincides with acceptance, the new sample stays valid and no overrun is flagged.
- enable_in low in any state:
  - next cycle → IDLE;
  - counters and divider clear;
  - rpm_valid_out and overrun_out clear;
  - rpm and sat outputs hold.
- Re-enable starts a fresh window at count 0.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0.
- Reset mid-conversion aborts the conversion; no partial result is published.
- Latency: boundary cycle t → rpm_valid_out high in cycle t+46 (1 snapshot + 44 divide + 1 publish).
- SAMPLE_TICKS ≥ 64 guarantees conversion finishes before the next boundary.
- Input-to-count latency: 3 cycles (2 sync + edge detect). Without debounce, the maximum countable rate is 1 edge per 2 cycles.
- Outputs are registered; no combinational input-to-output paths.

## Configuration
- TACH_SCHED_DEBOUNCE_EN defined:
  - each synchronized input feeds a filter; the filtered level changes only after the raw level holds for DEBOUNCE_CYCLES consecutive cycles;
  - edges are taken on the filtered level;
  - input-to-count latency becomes 3 + DEBOUNCE_CYCLES cycles.
- Undefined: no filter; DEBOUNCE_CYCLES is unused; latency is 3 cycles.

## Test plan
- SAMPLE_TICKS=1000, 30 edges on A and 12 on B per window, ready held 1 → rpm_a_out=500, rpm_b_out=200, rpm_valid_out high exactly 46 cycles after the boundary for 1 cycle.
- 1 edge A, 3 edges B → rpm_a_out=16, rpm_b_out=50. Zero edges → 0, sat flags 0.
- 70 edges on A → rpm_a_out=1023, sat_a_out=1. Next window with 6 edges → 100, sat_a_out=0.
- rpm_ready_in low across two boundaries → overrun_out=1 after second PUBLISH with second-window values. Enable toggled low → overrun_out=0.
- Edge landing in the boundary cycle counted in old window (count N+1); edge in the following cycle counted in new window.
- reset_n_in pulsed low during DIV_B → all outputs 0 immediately and no valid strobe. Deassert then enable → first sample one full window later.

Source files
------------

// File: rtl/tach_sample_scheduler.sv
// Two-channel tachometer window sampler with a shared serial divide-by-3 RPM converter and valid/ready publish.
// Optional per-input debounce filter when TACH_SCHED_DEBOUNCE_EN is defined.
module tach_sample_scheduler #(
   parameter int unsigned SAMPLE_TICKS    = 1_250_000,
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic       clk_in,
   input  logic       reset_n_in,
   input  logic       enable_in,
   input  logic       tach_a_in,
   input  logic       tach_b_in,
   input  logic       rpm_ready_in,
   output logic [9:0] rpm_a_out,
   output logic [9:0] rpm_b_out,
   output logic       rpm_valid_out,
   output logic       sat_a_out,
   output logic       sat_b_out,
   output logic       overrun_out
);
   localparam int unsigned WIN_W = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NUM_W = 22;
   localparam int unsigned RPM_W = 10;
   localparam int unsigned DIV_W = 5;
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(SAMPLE_TICKS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(NUM_W - 1);
   localparam logic [NUM_W-1:0] RPM_SCALE = NUM_W'(50);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COUNT   = 3'd1;
   localparam logic [2:0] ST_DIV_A   = 3'd2;
   localparam logic [2:0] ST_DIV_B   = 3'd3;
   localparam logic [2:0] ST_PUBLISH = 3'd4;

   logic [2:0]       state, state_nx;
   logic [1:0]       sync1, sync2, prev, lvl_c, edge_c;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] cnt_a, cnt_b, snap_b, cnt_a_inc_c, cnt_b_inc_c;
   logic [NUM_W-1:0] div_num, q_c;
   logic [NUM_W-2:0] div_quo;
   logic [1:0]       div_rem, rem_nx_c;
   logic [2:0]       rem_sh_c;
   logic [DIV_W-1:0] div_cnt;
   logic [RPM_W-1:0] res_a, res_b, q_rpm_c;
   logic             res_sat_a, res_sat_b, ge_c, q_sat_c, boundary_c, div_last_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
      return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
   endfunction

`ifdef TACH_SCHED_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]      filt;
   logic [DB_W-1:0] db_cnt [2];

   // Filtered level follows the synchronized level only after it has held for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         filt      <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign lvl_c = filt;
`else
   logic unused_debounce;
   assign unused_debounce = ^DEBOUNCE_CYCLES;
   assign lvl_c = sync2;
`endif

   assign edge_c      = lvl_c & ~prev;
   assign cnt_a_inc_c = sat_inc(cnt_a, edge_c[0]);
   assign cnt_b_inc_c = sat_inc(cnt_b, edge_c[1]);
   assign boundary_c  = (state != ST_IDLE) && (win_cnt == WIN_LAST);
   assign div_last_c  = (div_cnt == DIV_LAST);

   // One restoring step of the divide-by-3: remainder never exceeds 2.
   assign rem_sh_c = {div_rem, div_num[NUM_W-1]};
   assign ge_c     = (rem_sh_c >= 3'd3);
   assign rem_nx_c = ge_c ? 2'(rem_sh_c - 3'd3) : rem_sh_c[1:0];
   assign q_c      = {div_quo, ge_c};
   assign q_sat_c  = |q_c[NUM_W-1:RPM_W];
   assign q_rpm_c  = q_sat_c ? '1 : q_c[RPM_W-1:0];

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state <= ST_IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (!enable_in) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    state_nx = ST_COUNT;
            ST_COUNT:   if (boundary_c) state_nx = ST_DIV_A;
            ST_DIV_A:   if (div_last_c) state_nx = ST_DIV_B;
            ST_DIV_B:   if (div_last_c) state_nx = ST_PUBLISH;
            ST_PUBLISH: state_nx = ST_COUNT;
            default:    state_nx = ST_IDLE;
         endcase
      end
   end

   // Window/edge counting, shared divider and publish handshake.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         sync1         <= '0;
         sync2         <= '0;
         prev          <= '0;
         win_cnt       <= '0;
         cnt_a         <= '0;
         cnt_b         <= '0;
         snap_b        <= '0;
         div_num       <= '0;
         div_rem       <= '0;
         div_quo       <= '0;
         div_cnt       <= '0;
         res_a         <= '0;
         res_b         <= '0;
         res_sat_a     <= 1'b0;
         res_sat_b     <= 1'b0;
         rpm_a_out     <= '0;
         rpm_b_out     <= '0;
         sat_a_out     <= 1'b0;
         sat_b_out     <= 1'b0;
         rpm_valid_out <= 1'b0;
         overrun_out   <= 1'b0;
      end else begin
         sync1 <= {tach_b_in, tach_a_in};
         sync2 <= sync1;
         prev  <= lvl_c;
         if (!enable_in) begin
            win_cnt       <= '0;
            cnt_a         <= '0;
            cnt_b         <= '0;
            div_num       <= '0;
            div_rem       <= '0;
            div_quo       <= '0;
            div_cnt       <= '0;
            rpm_valid_out <= 1'b0;
            overrun_out   <= 1'b0;
         end else begin
            if (state != ST_IDLE) begin
               if (boundary_c) begin
                  win_cnt <= '0;
                  cnt_a   <= '0;
                  cnt_b   <= '0;
               end else begin
                  win_cnt <= win_cnt + WIN_W'(1);
                  cnt_a   <= cnt_a_inc_c;
                  cnt_b   <= cnt_b_inc_c;
               end
            end
            if ((state == ST_COUNT) && boundary_c) begin
               div_num <= NUM_W'(cnt_a_inc_c) * RPM_SCALE;
               snap_b  <= cnt_b_inc_c;
               div_rem <= '0;
               div_quo <= '0;
               div_cnt <= '0;
            end
            if ((state == ST_DIV_A) || (state == ST_DIV_B)) begin
               div_num <= div_num << 1;
               div_rem <= rem_nx_c;
               div_quo <= {div_quo[NUM_W-3:0], ge_c};
               div_cnt <= div_cnt + DIV_W'(1);
               if (div_last_c) begin
                  div_cnt <= '0;
                  div_rem <= '0;
                  div_quo <= '0;
                  if (state == ST_DIV_A) begin
                     res_a     <= q_rpm_c;
                     res_sat_a <= q_sat_c;
                     div_num   <= NUM_W'(snap_b) * RPM_SCALE;
                  end else begin
                     res_b     <= q_rpm_c;
                     res_sat_b <= q_sat_c;
                  end
               end
            end
            if (state == ST_PUBLISH) begin
               rpm_a_out     <= res_a;
               rpm_b_out     <= res_b;
               sat_a_out     <= res_sat_a;
               sat_b_out     <= res_sat_b;
               rpm_valid_out <= 1'b1;
               overrun_out   <= overrun_out | (rpm_valid_out & ~rpm_ready_in);
            end else if (rpm_valid_out && rpm_ready_in) begin
               rpm_valid_out <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_tach_sample_scheduler.sv
// Randomized self-checking bench for tach_sample_scheduler against a window/edge-count reference model.
module tb_tach_sample_scheduler;
   localparam int unsigned ST    = 1000;
   localparam int          NEVER = 1_000_000;

   logic       clk_in       = 1'b0;
   logic       reset_n_in   = 1'b0;
   logic       enable_in    = 1'b0;
   logic       tach_a_in    = 1'b0;
   logic       tach_b_in    = 1'b0;
   logic       rpm_ready_in = 1'b0;
   logic [9:0] rpm_a_out, rpm_b_out;
   logic       rpm_valid_out, sat_a_out, sat_b_out, overrun_out;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   en_cyc = 0;
   int   cur_w = 0;
   int   exp_a [32];
   int   exp_b [32];
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;
   logic en_model = 1'b0;

   typedef struct {
      logic       v45, v46, v47, vany;
      logic [9:0] a, b;
      logic       sa, sb, ov;
   } obs_t;

   tach_sample_scheduler #(.SAMPLE_TICKS(ST), .DEBOUNCE_CYCLES(8)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .enable_in(enable_in),
      .tach_a_in(tach_a_in), .tach_b_in(tach_b_in), .rpm_ready_in(rpm_ready_in),
      .rpm_a_out(rpm_a_out), .rpm_b_out(rpm_b_out), .rpm_valid_out(rpm_valid_out),
      .sat_a_out(sat_a_out), .sat_b_out(sat_b_out), .overrun_out(overrun_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic int rpm_of(input int n);
      int q;
      q = n * 50 / 3;
      return (q > 1023) ? 1023 : q;
   endfunction

   function automatic logic sat_of(input int n);
      return (n * 50 / 3) > 1023;
   endfunction

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   // Reference: a rising edge driven now reaches the counter 2 cycles later; windows are ST cycles from enable+1.
   task automatic drive(input logic a, input logic b);
      int w;
      if (en_model) begin
         w = (cyc + 2 - en_cyc - 1) / int'(ST);
         if (a && !prev_a && w < 32) exp_a[w]++;
         if (b && !prev_b && w < 32) exp_b[w]++;
      end
      prev_a = a;
      prev_b = b;
      tach_a_in = a;
      tach_b_in = b;
   endtask

   task automatic start_run;
      enable_in = 1'b1;
      en_cyc = cyc;
      cur_w = 0;
      for (int i = 0; i < 32; i++) begin
         exp_a[i] = 0;
         exp_b[i] = 0;
      end
      en_model = 1'b1;
   endtask

   task automatic restart;
      enable_in = 1'b0;
      en_model = 1'b0;
      tick();
      tick();
      start_run();
   endtask

   task automatic run_window(input int na, input int nb, input int rdy_from, input bit bnd, output obs_t o);
      int a_next, b_next, a_left, b_left;
      logic a, b;
      a_next = int'($urandom_range(50, 100));
      b_next = int'($urandom_range(50, 100));
      a_left = na;
      b_left = nb;
      o.vany = 1'b0;
      for (int r = 0; r < int'(ST); r++) begin
         a = (a_left > 0) && (r == a_next);
         b = (b_left > 0) && (r == b_next);
         if (a) begin a_left--; a_next += int'($urandom_range(2, 4)); end
         if (b) begin b_left--; b_next += int'($urandom_range(2, 4)); end
         if (bnd && r == int'(ST) - 2) a = 1'b1;
         if (bnd && r == int'(ST) - 1) b = 1'b1;
         drive(a, b);
         rpm_ready_in = (r >= rdy_from);
         o.vany = o.vany | rpm_valid_out;
         if (r == 45) o.v45 = rpm_valid_out;
         if (r == 46) begin
            o.v46 = rpm_valid_out;
            o.a = rpm_a_out; o.b = rpm_b_out;
            o.sa = sat_a_out; o.sb = sat_b_out; o.ov = overrun_out;
         end
         if (r == 47) o.v47 = rpm_valid_out;
         tick();
      end
      cur_w++;
   endtask

   task automatic test_reset;
      reset_n_in = 1'b0;
      tick(); tick(); tick();
      checks++; if (rpm_a_out !== 10'd0) begin errors++; $display("FAIL reset_rpm_a: got %0d expected 0", rpm_a_out); end
      checks++; if (rpm_b_out !== 10'd0) begin errors++; $display("FAIL reset_rpm_b: got %0d expected 0", rpm_b_out); end
      checks++; if ({rpm_valid_out, sat_a_out, sat_b_out, overrun_out} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {rpm_valid_out, sat_a_out, sat_b_out, overrun_out});
      end
      reset_n_in = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      obs_t o;
      restart();
      run_window(30, 12, 0, 0, o);
      checks++; if (o.vany !== 1'b0) begin errors++; $display("FAIL basic_first_window_valid: got %b expected 0", o.vany); end
      run_window(1, 3, 0, 0, o);
      checks++; if ({o.v45, o.v46, o.v47} !== 3'b010) begin errors++; $display("FAIL basic_valid_timing: got %b expected 010", {o.v45, o.v46, o.v47}); end
      checks++; if (o.a !== 10'd500) begin errors++; $display("FAIL basic_rpm_a: got %0d expected 500", o.a); end
      checks++; if (o.b !== 10'd200) begin errors++; $display("FAIL basic_rpm_b: got %0d expected 200", o.b); end
      run_window(0, 0, 0, 0, o);
      checks++; if (o.a !== 10'd16 || o.b !== 10'd50) begin errors++; $display("FAIL basic_small: got %0d/%0d expected 16/50", o.a, o.b); end
      run_window(70, 0, 0, 0, o);
      checks++; if (o.a !== 10'd0 || o.b !== 10'd0 || o.sa !== 1'b0 || o.sb !== 1'b0) begin
         errors++; $display("FAIL basic_zero: got %0d/%0d sat %b%b expected 0/0 sat 00", o.a, o.b, o.sa, o.sb);
      end
   endtask

   task automatic test_saturation;
      obs_t o;
      run_window(6, 0, 0, 0, o);
      checks++; if (o.a !== 10'd1023 || o.sa !== 1'b1) begin errors++; $display("FAIL sat_clamp: got %0d sat %b expected 1023 sat 1", o.a, o.sa); end
      checks++; if (o.sb !== 1'b0) begin errors++; $display("FAIL sat_b_clear: got %b expected 0", o.sb); end
      run_window(0, 0, 0, 0, o);
      checks++; if (o.a !== 10'd100 || o.sa !== 1'b0) begin errors++; $display("FAIL sat_recover: got %0d sat %b expected 100 sat 0", o.a, o.sa); end
   endtask

   task automatic test_random;
      obs_t o;
      int na, nb, ea, eb;
      restart();
      for (int k = 0; k < 8; k++) begin
         na = int'($urandom_range(0, 70));
         nb = int'($urandom_range(0, 70));
         run_window(na, nb, 0, 0, o);
         if (k > 0) begin
            ea = exp_a[cur_w - 2];
            eb = exp_b[cur_w - 2];
            checks++; if ({o.v45, o.v46, o.v47} !== 3'b010) begin errors++; $display("FAIL rand_valid_timing w%0d: got %b expected 010", k, {o.v45, o.v46, o.v47}); end
            checks++; if (o.a !== 10'(rpm_of(ea)) || o.sa !== sat_of(ea)) begin
               errors++; $display("FAIL rand_rpm_a w%0d: got %0d sat %b expected %0d sat %b", k, o.a, o.sa, rpm_of(ea), sat_of(ea));
            end
            checks++; if (o.b !== 10'(rpm_of(eb)) || o.sb !== sat_of(eb)) begin
               errors++; $display("FAIL rand_rpm_b w%0d: got %0d sat %b expected %0d sat %b", k, o.b, o.sb, rpm_of(eb), sat_of(eb));
            end
         end
      end
   endtask

   task automatic test_boundary;
      obs_t o;
      restart();
      run_window(5, 4, 0, 1, o);
      run_window(2, 2, 0, 0, o);
      checks++; if (o.a !== 10'd100) begin errors++; $display("FAIL bnd_old_window_a: got %0d expected 100", o.a); end
      checks++; if (o.b !== 10'd66) begin errors++; $display("FAIL bnd_old_window_b: got %0d expected 66", o.b); end
      run_window(0, 0, 0, 0, o);
      checks++; if (o.a !== 10'd33) begin errors++; $display("FAIL bnd_new_window_a: got %0d expected 33", o.a); end
      checks++; if (o.b !== 10'd50) begin errors++; $display("FAIL bnd_new_window_b: got %0d expected 50", o.b); end
   endtask

   task automatic test_overrun;
      obs_t o;
      restart();
      run_window(3, 0, 0, 0, o);
      run_window(6, 0, NEVER, 0, o);
      checks++; if (o.a !== 10'd50 || o.v47 !== 1'b1 || o.ov !== 1'b0) begin
         errors++; $display("FAIL ovr_hold: got %0d v47 %b ov %b expected 50 v47 1 ov 0", o.a, o.v47, o.ov);
      end
      run_window(9, 0, 45, 0, o);
      checks++; if (o.a !== 10'd100 || o.v46 !== 1'b1 || o.ov !== 1'b0 || o.v47 !== 1'b0) begin
         errors++; $display("FAIL ovr_coincide: got %0d v46 %b ov %b v47 %b expected 100 1 0 0", o.a, o.v46, o.ov, o.v47);
      end
      run_window(12, 0, NEVER, 0, o);
      checks++; if (o.a !== 10'd150 || o.ov !== 1'b0 || o.v47 !== 1'b1) begin
         errors++; $display("FAIL ovr_first_pending: got %0d ov %b v47 %b expected 150 0 1", o.a, o.ov, o.v47);
      end
      run_window(0, 0, NEVER, 0, o);
      checks++; if (o.a !== 10'd200 || o.ov !== 1'b1 || o.v46 !== 1'b1) begin
         errors++; $display("FAIL ovr_flag: got %0d ov %b v46 %b expected 200 1 1", o.a, o.ov, o.v46);
      end
      enable_in = 1'b0;
      en_model = 1'b0;
      tick();
      checks++; if (overrun_out !== 1'b0 || rpm_valid_out !== 1'b0) begin
         errors++; $display("FAIL ovr_disable_clear: got ov %b valid %b expected 0 0", overrun_out, rpm_valid_out);
      end
      checks++; if (rpm_a_out !== 10'd200) begin errors++; $display("FAIL ovr_disable_hold: got %0d expected 200", rpm_a_out); end
   endtask

   task automatic test_reset_midconv;
      obs_t o;
      restart();
      run_window(12, 30, 0, 0, o);
      for (int r = 0; r < 30; r++) begin
         drive(1'b0, 1'b0);
         rpm_ready_in = 1'b1;
         tick();
      end
      reset_n_in = 1'b0;
      en_model = 1'b0;
      #1;
      checks++; if (rpm_a_out !== 10'd0 || rpm_b_out !== 10'd0) begin
         errors++; $display("FAIL midreset_rpm: got %0d/%0d expected 0/0", rpm_a_out, rpm_b_out);
      end
      checks++; if ({rpm_valid_out, sat_a_out, sat_b_out, overrun_out} !== 4'b0) begin
         errors++; $display("FAIL midreset_flags: got %b expected 0000", {rpm_valid_out, sat_a_out, sat_b_out, overrun_out});
      end
      tick();
      tick();
      reset_n_in = 1'b1;
      start_run();
      run_window(4, 5, 0, 0, o);
      checks++; if (o.vany !== 1'b0) begin errors++; $display("FAIL midreset_no_strobe: got %b expected 0", o.vany); end
      run_window(0, 0, 0, 0, o);
      checks++; if (o.v46 !== 1'b1 || o.a !== 10'd66 || o.b !== 10'd83) begin
         errors++; $display("FAIL midreset_first_sample: got v %b %0d/%0d expected v 1 66/83", o.v46, o.a, o.b);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_random();
      test_boundary();
      test_overrun();
      test_reset_midconv();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
